// File: rtl/sha_pkg.sv
// Shared SHA-256 constants and types, used by the padder and the rest of the SHA datapath.
package sha_pkg;

  localparam int SHA_BLOCK_BITS  = 512;
  localparam int SHA_BLOCK_BYTES = 64;
  localparam int SHA_LEN_OFF     = 56;
  localparam logic [7:0] SHA_PAD_BYTE = 8'h80;

  typedef logic [SHA_BLOCK_BITS-1:0] sha_block_t;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    EXTRA,
    DRAIN
  } pad_state_t;

endpackage

// File: rtl/sha_msg_padder_if.sv
// Input beat stream and padded output block stream of the SHA message padder.
interface sha_msg_padder_if #(
  parameter int DATA_W = 512
);

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last
  );

endinterface

// File: rtl/sha_pad_mask.sv
// Builds a padded block: keeps bytes below rem, optionally drops in the 0x80 marker at byte rem
// and the big-endian 64-bit bit length in bytes 56..63.
module sha_pad_mask
  import sha_pkg::*;
(
  input  sha_block_t  beat,
  input  logic [5:0]  rem,
  input  logic        put_pad,
  input  logic        put_len,
  input  logic [63:0] bitlen,
  output sha_block_t  padded
);

  // rem==0 means the beat is completely filled with message bytes.
  always_comb begin
    padded = '0;
    for (int i = 0; i < SHA_BLOCK_BYTES; i++) begin
      if (rem == 6'd0 || 6'(i) < rem) begin
        padded[8*i +: 8] = beat[8*i +: 8];
      end
    end
    if (put_pad) begin
      padded[{rem, 3'b000} +: 8] = SHA_PAD_BYTE;
    end
    if (put_len) begin
      for (int k = 0; k < 8; k++) begin
        padded[8*(SHA_LEN_OFF+k) +: 8] = bitlen[8*(7-k) +: 8];
      end
    end
  end

endmodule

// File: rtl/sha_msg_padder.sv
// Streaming SHA-256 message padder: passes message beats through and appends the 0x80 marker,
// zero fill and 64-bit bit length, adding an extra block when the final beat has no room.
module sha_msg_padder
  import sha_pkg::*;
#(
  parameter int LEN_W  = 48,
  parameter int DATA_W = 512
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] msg_bytes,
  output logic             busy,
  output logic             done,
  sha_msg_padder_if.slave  bus
);

  generate
    if (DATA_W != SHA_BLOCK_BITS) begin : g_bad_data_w
      $error("sha_msg_padder: DATA_W must be 512");
    end
    if (LEN_W > 61 || LEN_W < 7) begin : g_bad_len_w
      $error("sha_msg_padder: LEN_W must be in 7..61");
    end
  endgenerate

  localparam int CNT_W = LEN_W - 5;

  pad_state_t       state;
  logic [CNT_W-1:0] beat_cnt;
  logic [5:0]       rem_q;
  logic             extra_q;
  logic [63:0]      bitlen_q;

  logic [5:0]       start_rem;
  logic [CNT_W-1:0] start_beats;
  logic             start_extra;
  logic             final_beat;
  logic             load_ok;
  logic             in_fire;
  sha_block_t       mask_beat;
  sha_block_t       padded;
  logic             put_pad;
  logic             put_len;

  assign start_rem   = msg_bytes[5:0];
  assign start_beats = CNT_W'(msg_bytes[LEN_W-1:6]) + CNT_W'(start_rem != 6'd0);
  assign start_extra = (start_rem == 6'd0) || (start_rem > 6'd55);

  assign final_beat  = (beat_cnt == CNT_W'(1));
  assign load_ok     = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = (state == STREAM) && load_ok;
  assign in_fire     = bus.in_valid && bus.in_ready;

  // The EXTRA block is the same masking path fed with an all-zero beat.
  assign mask_beat = (state == EXTRA) ? '0 : bus.in_data;
  assign put_pad   = (state == EXTRA) ? (rem_q == 6'd0) : (rem_q != 6'd0);
  assign put_len   = (state == EXTRA) || !extra_q;

  sha_pad_mask u_mask (
    .beat    (mask_beat),
    .rem     (rem_q),
    .put_pad (put_pad),
    .put_len (put_len),
    .bitlen  (bitlen_q),
    .padded  (padded)
  );

  // done is raised one cycle after the last handshake while busy is still high, so a start
  // coinciding with done lands in DRAIN and is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      beat_cnt      <= '0;
      rem_q         <= '0;
      extra_q       <= 1'b0;
      bitlen_q      <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      bus.out_data  <= '0;
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (bus.out_valid && bus.out_ready) begin
        bus.out_valid <= 1'b0;
        bus.out_last  <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (start) begin
            beat_cnt <= start_beats;
            rem_q    <= start_rem;
            extra_q  <= start_extra;
            bitlen_q <= 64'({msg_bytes, 3'b000});
            busy     <= 1'b1;
            state    <= (start_beats != '0) ? STREAM : EXTRA;
          end
        end
        STREAM: begin
          if (in_fire) begin
            bus.out_data  <= final_beat ? padded : bus.in_data;
            bus.out_valid <= 1'b1;
            bus.out_last  <= final_beat && !extra_q;
            beat_cnt      <= beat_cnt - CNT_W'(1);
            if (final_beat) begin
              state <= extra_q ? EXTRA : DRAIN;
            end
          end
        end
        EXTRA: begin
          if (load_ok) begin
            bus.out_data  <= padded;
            bus.out_valid <= 1'b1;
            bus.out_last  <= 1'b1;
            state         <= DRAIN;
          end
        end
        DRAIN: begin
          if (done) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (bus.out_valid && bus.out_ready && bus.out_last) begin
            done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha_msg_padder.sv
// Randomized bench for sha_msg_padder against a byte-level FIPS 180-4 padding model.
module tb_sha_msg_padder;
  import sha_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [47:0] msg_bytes;
  logic        busy;
  logic        done;

  sha_msg_padder_if #(.DATA_W(512)) bus ();

  sha_msg_padder #(.LEN_W(48), .DATA_W(512)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .msg_bytes (msg_bytes),
    .busy      (busy),
    .done      (done),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  byte unsigned msg[$];
  sha_block_t   exp_q[$];
  sha_block_t   got_q[$];
  bit           got_last_q[$];
  int           in_hs;
  int           exp_hs;
  int           done_cnt;
  int           stable_err;
  int           busy_after;
  int           ready_after;
  bit           timed_out;

  // Reference padding: message bytes, 0x80, zeros up to 56 mod 64, then 64-bit big-endian bit count.
  function automatic void build_expected(input int len);
    byte unsigned p[$];
    logic [63:0]  bl;
    sha_block_t   blk;
    exp_q.delete();
    for (int i = 0; i < len; i++) p.push_back(msg[i]);
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bl = 64'(len) * 64'd8;
    for (int k = 7; k >= 0; k--) p.push_back(bl[8*k +: 8]);
    for (int b = 0; b < p.size() / 64; b++) begin
      blk = '0;
      for (int j = 0; j < 64; j++) blk[8*j +: 8] = p[64*b + j];
      exp_q.push_back(blk);
    end
  endfunction

  // Drives one message, captures accepted output blocks and handshake statistics.
  task automatic run_message(input int len, input bit use_abc, input bit rand_ready,
                             input bit rand_valid, input bit hold_valid, input bit start_on_done);
    sha_block_t beats[$];
    sha_block_t w;
    sha_block_t prev_data;
    bit         prev_stall;
    int         nbeats;
    int         bi;
    int         cyc;
    int         post;
    nbeats = (len + 63) / 64;
    msg.delete();
    for (int i = 0; i < len; i++) msg.push_back(use_abc ? 8'(8'h61 + i) : 8'($urandom));
    for (int b = 0; b < nbeats; b++) begin
      for (int j = 0; j < 64; j++)
        w[8*j +: 8] = (b*64 + j < len) ? msg[b*64 + j] : 8'($urandom);
      beats.push_back(w);
    end
    build_expected(len);
    got_q.delete();
    got_last_q.delete();
    in_hs = 0; exp_hs = nbeats; done_cnt = 0; stable_err = 0;
    busy_after = 0; ready_after = 0; timed_out = 1'b0;
    prev_stall = 1'b0; prev_data = '0; bi = 0; cyc = 0; post = -1;
    while (post != 0 && cyc < 3000) begin
      @(negedge clk);
      start     = (cyc == 0) || (start_on_done && done);
      msg_bytes = (cyc == 0) ? 48'(len) : 48'd3;
      bus.in_valid = (bi < nbeats) ? (rand_valid ? 1'($urandom_range(0, 1)) : 1'b1) : hold_valid;
      for (int j = 0; j < 16; j++) w[32*j +: 32] = $urandom;
      bus.in_data   = (bi < nbeats) ? beats[bi] : w;
      bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (bus.in_valid && bus.in_ready) begin
        bi++;
        in_hs++;
      end
      if (prev_stall && (!bus.out_valid || bus.out_data !== prev_data)) stable_err++;
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      if (bus.out_valid && bus.out_ready) begin
        got_q.push_back(bus.out_data);
        got_last_q.push_back(bus.out_last);
      end
      if (done) done_cnt++;
      if (post > 0) begin
        if (busy) busy_after++;
        if (bus.in_ready) ready_after++;
        post--;
      end else if (done && post < 0) begin
        post = 3;
      end
      cyc++;
    end
    @(negedge clk);
    start = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    if (post != 0) timed_out = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; msg_bytes = '0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done got=%b exp=0", done); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    total++; if (bus.out_last !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_last got=%b exp=0", bus.out_last); end
    total++; if (bus.out_data !== '0) begin bad++; $display("[TB] FAIL reset_out_data got=%h exp=0", bus.out_data); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_short_l3();
    run_message(3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    total++; if (timed_out !== 1'b0) begin bad++; $display("[TB] FAIL l3_timeout got=%b exp=0", timed_out); end
    total++; if (got_q.size() !== exp_q.size()) begin bad++; $display("[TB] FAIL l3_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int b = 0; b < exp_q.size() && b < got_q.size(); b++) begin
      total++; if (got_q[b] !== exp_q[b]) begin bad++; $display("[TB] FAIL l3_block%0d got=%h exp=%h", b, got_q[b], exp_q[b]); end
      total++; if (got_last_q[b] !== (b == exp_q.size()-1)) begin bad++; $display("[TB] FAIL l3_last%0d got=%b", b, got_last_q[b]); end
    end
    if (got_q.size() > 0) begin
      total++; if (got_q[0][31:0] !== 32'h80636261) begin bad++; $display("[TB] FAIL l3_bytes0_3 got=%h exp=80636261", got_q[0][31:0]); end
      total++; if (got_q[0][511:504] !== 8'h18) begin bad++; $display("[TB] FAIL l3_byte63 got=%h exp=18", got_q[0][511:504]); end
    end
    total++; if (done_cnt !== 1) begin bad++; $display("[TB] FAIL l3_done got=%0d exp=1", done_cnt); end
    total++; if (in_hs !== exp_hs) begin bad++; $display("[TB] FAIL l3_in_hs got=%0d exp=%0d", in_hs, exp_hs); end
    total++; if (ready_after !== 0) begin bad++; $display("[TB] FAIL l3_in_ready_after got=%0d exp=0", ready_after); end
  endtask

  task automatic test_exact_l64();
    run_message(64, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    total++; if (got_q.size() !== 2 || timed_out) begin bad++; $display("[TB] FAIL l64_count got=%0d exp=2", got_q.size()); end
    for (int b = 0; b < exp_q.size() && b < got_q.size(); b++) begin
      total++; if (got_q[b] !== exp_q[b]) begin bad++; $display("[TB] FAIL l64_block%0d got=%h exp=%h", b, got_q[b], exp_q[b]); end
      total++; if (got_last_q[b] !== (b == exp_q.size()-1)) begin bad++; $display("[TB] FAIL l64_last%0d got=%b", b, got_last_q[b]); end
    end
    if (got_q.size() == 2) begin
      total++; if (got_q[1][7:0] !== 8'h80) begin bad++; $display("[TB] FAIL l64_pad got=%h exp=80", got_q[1][7:0]); end
      total++; if (got_q[1][511:496] !== 16'h0002) begin bad++; $display("[TB] FAIL l64_len got=%h exp=0002", got_q[1][511:496]); end
    end
    total++; if (in_hs !== exp_hs) begin bad++; $display("[TB] FAIL l64_in_hs got=%0d exp=%0d", in_hs, exp_hs); end
  endtask

  task automatic test_boundary_l56();
    run_message(56, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    total++; if (got_q.size() !== 2 || timed_out) begin bad++; $display("[TB] FAIL l56_count got=%0d exp=2", got_q.size()); end
    for (int b = 0; b < exp_q.size() && b < got_q.size(); b++) begin
      total++; if (got_q[b] !== exp_q[b]) begin bad++; $display("[TB] FAIL l56_block%0d got=%h exp=%h", b, got_q[b], exp_q[b]); end
    end
    if (got_q.size() == 2) begin
      total++; if (got_q[0][511:448] !== 64'h80) begin bad++; $display("[TB] FAIL l56_tail got=%h exp=80", got_q[0][511:448]); end
      total++; if (got_q[1] !== {8'hC0, 8'h01, 496'h0}) begin bad++; $display("[TB] FAIL l56_extra got=%h", got_q[1]); end
      total++; if (got_last_q[0] !== 1'b0 || got_last_q[1] !== 1'b1) begin bad++; $display("[TB] FAIL l56_last got=%b%b exp=01", got_last_q[0], got_last_q[1]); end
    end
  endtask

  task automatic test_empty_l0();
    run_message(0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    total++; if (got_q.size() !== 1 || timed_out) begin bad++; $display("[TB] FAIL l0_count got=%0d exp=1", got_q.size()); end
    if (got_q.size() > 0) begin
      total++; if (got_q[0] !== 512'h80) begin bad++; $display("[TB] FAIL l0_block got=%h exp=80", got_q[0]); end
      total++; if (got_last_q[0] !== 1'b1) begin bad++; $display("[TB] FAIL l0_last got=%b exp=1", got_last_q[0]); end
    end
    total++; if (in_hs !== 0) begin bad++; $display("[TB] FAIL l0_in_hs got=%0d exp=0", in_hs); end
    total++; if (done_cnt !== 1) begin bad++; $display("[TB] FAIL l0_done got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_stall_l200();
    run_message(200, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    total++; if (got_q.size() !== 4 || timed_out) begin bad++; $display("[TB] FAIL l200_count got=%0d exp=4", got_q.size()); end
    for (int b = 0; b < exp_q.size() && b < got_q.size(); b++) begin
      total++; if (got_q[b] !== exp_q[b]) begin bad++; $display("[TB] FAIL l200_block%0d got=%h exp=%h", b, got_q[b], exp_q[b]); end
      total++; if (got_last_q[b] !== (b == exp_q.size()-1)) begin bad++; $display("[TB] FAIL l200_last%0d got=%b", b, got_last_q[b]); end
    end
    if (got_q.size() == 4) begin
      total++; if (got_q[3][511:496] !== 16'h4006) begin bad++; $display("[TB] FAIL l200_len got=%h exp=4006", got_q[3][511:496]); end
    end
    total++; if (stable_err !== 0) begin bad++; $display("[TB] FAIL l200_stable got=%0d exp=0", stable_err); end
  endtask

  task automatic test_reset_mid();
    int waited;
    @(negedge clk);
    start = 1'b1; msg_bytes = 48'd200; bus.in_valid = 1'b1; bus.in_data = '1; bus.out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    waited = 0;
    while (!bus.out_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("[TB] FAIL rstmid_setup got=%b exp=1", bus.out_valid); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_out_valid got=%b exp=0", bus.out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_busy got=%b exp=0", busy); end
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    run_message(3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    total++; if (got_q.size() !== 1 || timed_out) begin bad++; $display("[TB] FAIL rstmid_count got=%0d exp=1", got_q.size()); end
    if (got_q.size() > 0) begin
      total++; if (got_q[0] !== exp_q[0]) begin bad++; $display("[TB] FAIL rstmid_block got=%h exp=%h", got_q[0], exp_q[0]); end
      total++; if (got_q[0][511:504] !== 8'h18 || got_q[0][31:24] !== 8'h80) begin bad++; $display("[TB] FAIL rstmid_bytes got=%h", got_q[0]); end
    end
  endtask

  task automatic test_back_to_back();
    int lens[8] = '{1, 55, 57, 63, 127, 128, 0, 0};
    lens[6] = $urandom_range(1, 300);
    lens[7] = $urandom_range(0, 300);
    foreach (lens[n]) begin
      run_message(lens[n], 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      total++; if (got_q.size() !== exp_q.size() || timed_out) begin bad++; $display("[TB] FAIL b2b_count L=%0d got=%0d exp=%0d", lens[n], got_q.size(), exp_q.size()); end
      for (int b = 0; b < exp_q.size() && b < got_q.size(); b++) begin
        total++; if (got_q[b] !== exp_q[b]) begin bad++; $display("[TB] FAIL b2b_block L=%0d b=%0d got=%h exp=%h", lens[n], b, got_q[b], exp_q[b]); end
        total++; if (got_last_q[b] !== (b == exp_q.size()-1)) begin bad++; $display("[TB] FAIL b2b_last L=%0d b=%0d got=%b", lens[n], b, got_last_q[b]); end
      end
      total++; if (in_hs !== exp_hs) begin bad++; $display("[TB] FAIL b2b_in_hs L=%0d got=%0d exp=%0d", lens[n], in_hs, exp_hs); end
      total++; if (stable_err !== 0) begin bad++; $display("[TB] FAIL b2b_stable L=%0d got=%0d exp=0", lens[n], stable_err); end
      total++; if (busy_after !== 0) begin bad++; $display("[TB] FAIL b2b_start_on_done L=%0d busy_cycles=%0d exp=0", lens[n], busy_after); end
      total++; if (done_cnt !== 1) begin bad++; $display("[TB] FAIL b2b_done L=%0d got=%0d exp=1", lens[n], done_cnt); end
    end
  endtask

  initial begin
    test_reset();
    test_short_l3();
    test_exact_l64();
    test_boundary_l56();
    test_empty_l0();
    test_stall_l200();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
